// File: rtl/i2c_target.sv
// I2C target for 32-bit word transfers: oversampled SCL/SDA, 7-bit address match, byte ACKs.
// Define I2C_TGT_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizers.
module i2c_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  own_addr,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_req,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic s_scl, s_sda, scl_q, sda_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;
    logic       scl_new, sda_new;
    assign scl_new = scl_sync[SYNC_STAGES-1];
    assign sda_new = sda_sync[SYNC_STAGES-1];

    // A level must be seen on two of three consecutive samples, so 1-clk pulses vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_new};
            sda_hist <= {sda_hist[0], sda_new};
            scl_filt <= (scl_new & scl_hist[0]) | (scl_new & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_filt <= (sda_new & sda_hist[0]) | (sda_new & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end
    assign s_scl = scl_filt;
    assign s_sda = sda_filt;
`else
    assign s_scl = scl_sync[SYNC_STAGES-1];
    assign s_sda = sda_sync[SYNC_STAGES-1];
`endif

    logic start_ev, stop_ev, rise, fall;
    assign start_ev = s_scl & scl_q & sda_q & ~s_sda;
    assign stop_ev  = s_scl & scl_q & ~sda_q & s_sda;
    assign rise     = s_scl & ~scl_q;
    assign fall     = ~s_scl & scl_q;

    state_t      state, state_d;
    logic [3:0]  bit_cnt, bit_cnt_d;
    logic [1:0]  byte_cnt, byte_cnt_d;
    logic [6:0]  shreg, shreg_d;
    logic        rw, rw_d;
    logic [31:0] word, word_d;
    logic [31:0] rx_data_d;
    logic        rx_valid_d, tx_req_d, sda_oe_d;
    logic [7:0]  cur_byte;

    assign cur_byte = {shreg, s_sda};
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            rw       <= 1'b0;
            word     <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            scl_q    <= s_scl;
            sda_q    <= s_sda;
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            byte_cnt <= byte_cnt_d;
            shreg    <= shreg_d;
            rw       <= rw_d;
            word     <= word_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            tx_req   <= tx_req_d;
            sda_oe   <= sda_oe_d;
        end
    end

    // bit_cnt counts SCL rises in the 9-clock frame; ACK states use 8/9 to tell the two falls apart.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        byte_cnt_d = byte_cnt;
        shreg_d    = shreg;
        rw_d       = rw;
        word_d     = word;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        sda_oe_d   = sda_oe;
        if (start_ev) begin
            state_d    = ADDR;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = 2'd0;
            sda_oe_d   = 1'b0;
        end else if (stop_ev) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: if (rise) begin
                    shreg_d   = cur_byte[6:0];
                    bit_cnt_d = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        if (cur_byte[7:1] == own_addr && own_addr != 7'h00) begin
                            state_d = ADDR_ACK;
                            rw_d    = cur_byte[0];
                            if (cur_byte[0]) begin
                                tx_req_d = 1'b1;
                                word_d   = tx_data;
                            end
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            bit_cnt_d = 4'd0;
                            if (state == ADDR_ACK && rw) begin
                                state_d  = RD_BYTE;
                                sda_oe_d = ~word[31];
                                word_d   = {word[30:0], 1'b0};
                            end else begin
                                state_d  = WR_BYTE;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end else if (rise) begin
                        bit_cnt_d = 4'd9;
                    end
                end
                WR_BYTE: if (rise) begin
                    shreg_d   = cur_byte[6:0];
                    bit_cnt_d = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_d    = WR_ACK;
                        word_d     = {word[23:0], cur_byte};
                        byte_cnt_d = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            rx_data_d  = {word[23:0], cur_byte};
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                RD_BYTE: begin
                    if (rise) begin
                        bit_cnt_d = bit_cnt + 4'd1;
                    end else if (fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_d  = RD_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~word[31];
                            word_d   = {word[30:0], 1'b0};
                        end
                    end
                end
                RD_ACK: if (rise) begin
                    if (!s_sda) begin
                        state_d    = RD_BYTE;
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            tx_req_d = 1'b1;
                            word_d   = tx_data;
                        end
                    end else begin
                        state_d  = IGNORE;
                        sda_oe_d = 1'b0;
                    end
                end
                IGNORE: sda_oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a host drives the open-drain bus; a transaction-level model predicts ACKs,
// read bytes, rx words and tx_req counts, and a per-cycle monitor checks the pulses against it.
module tb_i2c_target;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  own_addr;
    logic        host_scl, host_sda;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [31:0] tx_data;
    logic        tx_req;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int tx_seen = 0;
    int tx_exp = 0;
    int model_cnt = 0;
    logic [31:0] model_word = '0;
    logic [31:0] exp_rx_q[$];

    always #5 clk = ~clk;

    assign sda_line = host_sda & ~sda_oe;

    i2c_target #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .own_addr (own_addr),
        .scl_i    (host_scl),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A START or STOP discards any partially written word.
    task automatic bus_start();
        host_scl = 1'b0; tick(5); host_sda = 1'b1; tick(5);
        host_scl = 1'b1; tick(10); host_sda = 1'b0; tick(10);
        model_cnt = 0;
    endtask

    task automatic bus_stop();
        host_scl = 1'b0; tick(5); host_sda = 1'b0; tick(5);
        host_scl = 1'b1; tick(10); host_sda = 1'b1; tick(10);
        model_cnt = 0;
    endtask

    // gbit >= 0 puts a 1-clk inverted pulse on SDA in the middle of that bit's SCL-high phase.
    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name, input int gbit);
        for (int i = 7; i >= 0; i--) begin
            host_scl = 1'b0; tick(5); host_sda = b[i]; tick(5);
            host_scl = 1'b1;
            if (i == gbit) begin
                tick(4); host_sda = ~b[i]; tick(1); host_sda = b[i]; tick(5);
            end else begin
                tick(10);
            end
        end
        host_scl = 1'b0; tick(5); host_sda = 1'b1; tick(5);
        host_scl = 1'b1; tick(5);
        check(name, sda_line, !exp_ack);
        tick(5);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic host_ack);
        for (int i = 7; i >= 0; i--) begin
            host_scl = 1'b0; tick(5); host_sda = 1'b1; tick(5);
            host_scl = 1'b1; tick(5); b[i] = sda_line; tick(5);
        end
        host_scl = 1'b0; tick(5); host_sda = !host_ack; tick(5);
        host_scl = 1'b1; tick(10);
    endtask

    task automatic write_txn(input logic [7:0] addr, input int n, input logic [63:0] data,
                             input bit do_stop, input int gbyte, input int gbit);
        bit hit;
        logic [7:0] b;
        hit = (addr[7:1] == own_addr) && (own_addr != 7'h00) && !addr[0];
        bus_start();
        send_byte(addr, hit, "wr_addr_ack", -1);
        if (hit) begin
            for (int k = 0; k < n; k++) begin
                b = 8'(data >> (8 * (n - 1 - k)));
                model_word = {model_word[23:0], b};
                model_cnt++;
                if (model_cnt == 4) begin
                    exp_rx_q.push_back(model_word);
                    model_cnt = 0;
                end
                send_byte(b, 1'b1, "wr_data_ack", (k == gbyte) ? gbit : -1);
            end
        end
        if (do_stop) bus_stop();
    endtask

    // Host ACKs every byte but the last; a new word is requested after each 4 ACKed bytes.
    task automatic read_txn(input logic [7:0] addr, input int n, input logic [31:0] w1,
                            input logic [31:0] w2, output logic [63:0] got);
        bit hit;
        logic [7:0] b, exp_b;
        hit = (addr[7:1] == own_addr) && (own_addr != 7'h00) && addr[0];
        got = '0;
        tx_data = w1;
        if (hit) begin
            tx_exp++;
            for (int k = 0; k < n - 1; k++) if (k % 4 == 3) tx_exp++;
        end
        bus_start();
        send_byte(addr, hit, "rd_addr_ack", -1);
        if (hit) begin
            for (int k = 0; k < n; k++) begin
                recv_byte(b, k != n - 1);
                exp_b = 8'(((k < 4) ? w1 : w2) >> (24 - 8 * (k % 4)));
                check("rd_byte", b, exp_b);
                got = {got[55:0], b};
                if (k == 0) tx_data = w2;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid || tx_req) check("rx_tx_exclusive", rx_valid & tx_req, 1'b0);
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx_q.size() != 0) check("rx_data", rx_data, exp_rx_q.pop_front());
                else check("rx_valid_spurious", rx_valid, 1'b0);
            end
            if (tx_req) begin
                check("tx_req_expected", tx_seen < tx_exp, 1'b1);
                tx_seen++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        int rx0, tx0;
        bit seen_oe;
        rst = 1'b1;
        own_addr = 7'h50;
        host_scl = 1'b1;
        host_sda = 1'b1;
        tx_data = '0;
        tick(3);
        check("reset_sda_oe", sda_oe, 1'b0);
        check("reset_rx_data", rx_data, 32'h0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_tx_req", tx_req, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick(5);

        // Full word write.
        rx0 = rx_cnt;
        write_txn(8'hA0, 4, 64'hDEADBEEF, 1'b1, -1, -1);
        check("t1_rx_data", rx_data, 32'hDEADBEEF);
        check("t1_rx_count", rx_cnt - rx0, 1);
        check("t1_busy_after_stop", busy, 1'b0);

        // Word read, NACK on the last byte.
        tx0 = tx_seen;
        read_txn(8'hA1, 4, 32'h12345678, 32'h0, got);
        check("t2_read_word", got[31:0], 32'h12345678);
        check("t2_tx_req_count", tx_seen - tx0, 1);
        check("t2_sda_oe_after_nack", sda_oe, 1'b0);
        check("t2_busy_in_ignore", busy, 1'b1);
        bus_stop();
        check("t2_busy_after_stop", busy, 1'b0);

        // Foreign address.
        rx0 = rx_cnt; tx0 = tx_seen;
        write_txn(8'hA2, 0, 64'h0, 1'b1, -1, -1);
        check("t3_busy_after_stop", busy, 1'b0);
        check("t3_no_pulses", (rx_cnt - rx0) + (tx_seen - tx0), 0);

        // Partial word discarded, then a full word.
        rx0 = rx_cnt;
        write_txn(8'hA0, 2, 64'h1122, 1'b1, -1, -1);
        check("t4_partial_no_rx", rx_cnt - rx0, 0);
        check("t4_rx_kept", rx_data, 32'hDEADBEEF);
        write_txn(8'hA0, 4, 64'hDEADBEEF, 1'b1, -1, -1);
        check("t4_rx_count", rx_cnt - rx0, 1);

        // Write one byte, then repeated START into a read.
        rx0 = rx_cnt; tx0 = tx_seen;
        write_txn(8'hA0, 1, 64'hAA, 1'b0, -1, -1);
        read_txn(8'hA1, 4, 32'h0F1E2D3C, 32'h0, got);
        check("t5_read_word", got[31:0], 32'h0F1E2D3C);
        check("t5_tx_req_count", tx_seen - tx0, 1);
        check("t5_no_rx", rx_cnt - rx0, 0);
        bus_stop();

        // Six-byte read crosses a word boundary and reloads from tx_data.
        tx0 = tx_seen;
        read_txn(8'hA1, 6, 32'hA5C30F96, 32'h3C5A7E81, got);
        check("t7_read_bytes", got[47:0], 48'hA5C30F963C5A);
        check("t7_tx_req_count", tx_seen - tx0, 2);
        bus_stop();

        // Asynchronous reset while the target drives the address ACK.
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            host_scl = 1'b0; tick(5); host_sda = (8'hA0 >> i) & 1'b1; tick(5);
            host_scl = 1'b1; tick(10);
        end
        host_scl = 1'b0;
        seen_oe = 1'b0;
        for (int i = 0; i < 20 && !seen_oe; i++) begin
            tick(1);
            seen_oe = sda_oe;
        end
        check("t6_ack_driven", seen_oe, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_sda_oe_async", sda_oe, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(3);
        bus_stop();
        check("t6_busy_after", busy, 1'b0);
        rx0 = rx_cnt;
        write_txn(8'hA0, 4, 64'h11223344, 1'b1, -1, -1);
        check("t6_rx_after_reset", rx_data, 32'h11223344);
        check("t6_rx_count", rx_cnt - rx0, 1);

`ifdef I2C_TGT_GLITCH_FILTER_EN
        // 1-clk SDA pulses while SCL is high: a fake STOP in 0xDE, a fake START in 0xAD.
        rx0 = rx_cnt;
        write_txn(8'hA0, 4, 64'hDEADBEEF, 1'b0, 0, 5);
        check("glitch_stop_rx", rx_data, 32'hDEADBEEF);
        write_txn(8'hA0, 4, 64'h5AADC3E7, 1'b1, 1, 7);
        check("glitch_start_rx", rx_data, 32'h5AADC3E7);
        check("glitch_rx_count", rx_cnt - rx0, 2);
`endif

        tick(5);
        check("exp_rx_drained", exp_rx_q.size(), 0);
        check("tx_req_total", tx_seen, tx_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
